bus_master_ctrl: RTL and testbench

Single-outstanding bus master for the shared parallel peripheral bus. It accepts read/write requests from an on-chip requester over a valid/ready handshake and drives the active-low RB/WB strobes, 8-bit address, data and PARITY through the master modport of `bus_if`. It waits for the slave's active-low ACK and returns one response per request, flagging read-parity errors and ACK timeouts. It sits directly upstream of the bus slaves.

---
 rtl/bus_master_ctrl_if.sv | 38 +++
 rtl/bus_master_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_bus_master_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_ctrl_if.sv
// bus_if: shared parallel peripheral bus.
//   rb, wb       : active-low read/write strobes (master -> slaves)
//   addr         : 8-bit target address (master -> slaves)
//   ack          : active-low acknowledge (slave -> master)
//   data, parity : bidirectional; each side supplies its drive value plus an enable.
interface bus_if #(
  parameter int unsigned BUS_WIDTH = 8
);
  logic                 rb;
  logic                 wb;
  logic [7:0]           addr;
  logic                 ack;

  // Per-side drive values and enables.
  logic [BUS_WIDTH-1:0] m_dout;
  logic                 m_par;
  logic                 m_oe;
  logic [BUS_WIDTH-1:0] s_dout;
  logic                 s_par;
  logic                 s_oe;

  // Resolved bus lines; they float when neither side drives.
  wire  [BUS_WIDTH-1:0] data;
  wire                  parity;

  assign data   = m_oe ? m_dout : (s_oe ? s_dout : {BUS_WIDTH{1'bz}});
  assign parity = m_oe ? m_par  : (s_oe ? s_par  : 1'bz);

  modport master (
    output rb, wb, addr, m_dout, m_par, m_oe,
    input  ack, data, parity
  );

  modport slave (
    input  rb, wb, addr, data, parity,
    output ack, s_dout, s_par, s_oe
  );
endinterface

// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl: single-outstanding master for the shared peripheral bus.
// It accepts one request at a time and drives the bus strobes, then returns one
// response per request. The response carries a read-parity flag and an ACK-timeout flag.
//   clk, rst        : clock; synchronous active-high reset
//   req_valid/ready : request handshake (ready only in IDLE and out of reset)
//   req_write       : 1 = write, 0 = read
//   req_addr        : target address
//   req_wdata       : write data
//   rsp_valid       : one-cycle completion pulse
//   rsp_rdata       : captured read data (held between reads)
//   rsp_parity_err  : read parity failure, qualified by rsp_valid
//   rsp_timeout     : no ACK within TIMEOUT cycles, qualified by rsp_valid
//   bus             : bus_if master modport
module bus_master_ctrl #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [7:0]           req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [BUS_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_parity_err,
  output logic                 rsp_timeout,
  bus_if.master                bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RELEASE} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [7:0]           r_addr, w_addr_nxt;
  logic [BUS_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_rb, w_rb_nxt;
  logic                 r_wb, w_wb_nxt;
  logic                 r_oe, w_oe_nxt;
  logic                 r_rsp_valid, w_rsp_valid_nxt;
  logic [BUS_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                 r_rsp_perr, w_rsp_perr_nxt;
  logic                 r_rsp_tout, w_rsp_tout_nxt;
  logic                 w_last;

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_last    = (r_cnt == CNT_LAST);

  // Next-state and registered-output logic.
  // A strobe is low only while we stay in WRITE/READ. Every exit path therefore
  // defaults it back high on the same edge that raises rsp_valid.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_par_nxt       = r_par;
    w_rb_nxt        = 1'b1;
    w_wb_nxt        = 1'b1;
    w_oe_nxt        = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_perr_nxt  = 1'b0;
    w_rsp_tout_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_addr_nxt  = req_addr;
          w_wdata_nxt = req_wdata;
          w_par_nxt   = ^req_wdata;
          w_cnt_nxt   = '0;
          if (req_write) begin
            w_state_nxt = S_WRITE;
            w_wb_nxt    = 1'b0;
            w_oe_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_READ;
            w_rb_nxt    = 1'b0;
          end
        end
      end

      S_WRITE: begin
        if (!bus.ack) begin
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RELEASE;
          w_cnt_nxt       = '0;
        end else if (w_last) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_tout_nxt  = 1'b1;
          w_state_nxt     = S_RELEASE;
          w_cnt_nxt       = '0;
        end else begin
          w_wb_nxt  = 1'b0;
          w_oe_nxt  = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_READ: begin
        if (!bus.ack) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = bus.data;
          w_rsp_perr_nxt  = (^bus.data) ^ bus.parity;
          w_state_nxt     = S_RELEASE;
          w_cnt_nxt       = '0;
        end else if (w_last) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_tout_nxt  = 1'b1;
          w_state_nxt     = S_RELEASE;
          w_cnt_nxt       = '0;
        end else begin
          w_rb_nxt  = 1'b0;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        // Wait for the slave to drop ACK. Give up after TIMEOUT cycles.
        if (bus.ack || w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_par       <= 1'b0;
      r_rb        <= 1'b1;
      r_wb        <= 1'b1;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_perr  <= 1'b0;
      r_rsp_tout  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_par       <= w_par_nxt;
      r_rb        <= w_rb_nxt;
      r_wb        <= w_wb_nxt;
      r_oe        <= w_oe_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_perr  <= w_rsp_perr_nxt;
      r_rsp_tout  <= w_rsp_tout_nxt;
    end
  end

  assign bus.rb         = r_rb;
  assign bus.wb         = r_wb;
  assign bus.addr       = r_addr;
  assign bus.m_dout     = r_wdata;
  assign bus.m_par      = r_par;
  assign bus.m_oe       = r_oe;

  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_parity_err = r_rsp_perr;
  assign rsp_timeout    = r_rsp_tout;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl; the bench plays the bus slave.
module tb_bus_master_ctrl;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [7:0]   req_addr;
  logic [W-1:0] req_wdata;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_parity_err;
  logic         rsp_timeout;

  always #5 clk = ~clk;

  bus_if #(.BUS_WIDTH(W)) bif ();

  bus_master_ctrl #(.BUS_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_parity_err (rsp_parity_err),
    .rsp_timeout    (rsp_timeout),
    .bus            (bif)
  );

  typedef struct packed {
    logic [W-1:0] rdata;
    logic         perr;
    logic         tout;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Scoreboard: every rsp_valid pulse pops and checks one expected response.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_expected", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
        chk("rsp_perr", 32'(rsp_parity_err), 32'(mon_e.perr));
        chk("rsp_tout", 32'(rsp_timeout), 32'(mon_e.tout));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [W-1:0] rd, input logic pe, input logic tt);
    sb.push_back('{rdata: rd, perr: pe, tout: tt});
  endtask

  // Present a request for one edge. Then scramble the fields to prove they are
  // sampled only at acceptance.
  task automatic issue(input logic wr, input logic [7:0] a, input logic [W-1:0] wd);
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    chk("issue_ready", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = ~a;
    req_wdata = ~wd;
  endtask

  // Slave side. The strobe is expected to stay low for lat cycles. If to=0, ACK
  // is driven low for the last of those edges; if to=1, ACK never comes.
  task automatic serve(input logic wr, input logic [7:0] a, input logic [W-1:0] wd,
                       input int lat, input logic to, input logic [W-1:0] sd, input logic sp);
    if (!wr) begin
      bif.s_dout = sd;
      bif.s_par  = sp;
      bif.s_oe   = 1'b1;
    end
    for (int i = 1; i <= lat; i++) begin
      chk("strobe_low", 32'(wr ? bif.wb : bif.rb), 32'd0);
      chk("other_strobe", 32'(wr ? bif.rb : bif.wb), 32'd1);
      chk("addr_stable", 32'(bif.addr), 32'(a));
      chk("master_oe", 32'(bif.m_oe), 32'(wr));
      if (wr) begin
        chk("wdata", 32'(bif.data), 32'(wd));
        chk("wparity", 32'(bif.parity), 32'(^wd));
      end
      chk("no_early_rsp", 32'(rsp_valid), 32'd0);
      if (i == lat && !to) bif.ack = 1'b0;
      cyc();
    end
    chk("strobe_high", 32'(bif.rb & bif.wb), 32'd1);
    chk("rsp_pulse", 32'(rsp_valid), 32'd1);
    chk("bus_released", 32'(bif.m_oe), 32'd0);
    bif.s_oe = 1'b0;
  endtask

  task automatic release_bus();
    bif.ack = 1'b1;
    chk("release_busy", 32'(req_ready), 32'd0);
    cyc();
    chk("ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    bif.ack    = 1'b1;
    bif.s_oe   = 1'b0;
    bif.s_dout = '0;
    bif.s_par  = 1'b0;
    cyc(); cyc(); cyc();

    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rb", 32'(bif.rb), 32'd1);
    chk("rst_wb", 32'(bif.wb), 32'd1);
    chk("rst_addr", 32'(bif.addr), 32'd0);
    chk("rst_oe", 32'(bif.m_oe), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_perr", 32'(rsp_parity_err), 32'd0);
    chk("rst_tout", 32'(rsp_timeout), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Write 0x5A to 0x21, ACK after 2 cycles.
    expect_rsp(8'h00, 1'b0, 1'b0);
    issue(1'b1, 8'h21, 8'h5A);
    serve(1'b1, 8'h21, 8'h5A, 2, 1'b0, 8'h00, 1'b0);
    release_bus();

    // Read 0x07 with correct parity.
    expect_rsp(8'h07, 1'b0, 1'b0);
    issue(1'b0, 8'h40, 8'h00);
    serve(1'b0, 8'h40, 8'h00, 1, 1'b0, 8'h07, 1'b1);
    release_bus();

    // Read 0x07 with bad parity.
    expect_rsp(8'h07, 1'b1, 1'b0);
    issue(1'b0, 8'h41, 8'h00);
    serve(1'b0, 8'h41, 8'h00, 3, 1'b0, 8'h07, 1'b0);
    release_bus();

    // Read 0xA5 (even weight) with PARITY 0.
    expect_rsp(8'hA5, 1'b0, 1'b0);
    issue(1'b0, 8'h42, 8'h00);
    serve(1'b0, 8'h42, 8'h00, 2, 1'b0, 8'hA5, 1'b0);
    release_bus();

    // Write with ACK held high: timeout after exactly TO cycles.
    expect_rsp(8'hA5, 1'b0, 1'b1);
    issue(1'b1, 8'h22, 8'h3C);
    serve(1'b1, 8'h22, 8'h3C, TO, 1'b1, 8'h00, 1'b0);
    release_bus();

    // ACK on the timeout edge wins.
    expect_rsp(8'hA5, 1'b0, 1'b0);
    issue(1'b1, 8'h23, 8'h81);
    serve(1'b1, 8'h23, 8'h81, TO, 1'b0, 8'h00, 1'b0);
    release_bus();

    // Slave holds ACK low 3 cycles; a queued read waits for it.
    expect_rsp(8'hA5, 1'b0, 1'b0);
    issue(1'b1, 8'h24, 8'h01);
    serve(1'b1, 8'h24, 8'h01, 1, 1'b0, 8'h00, 1'b0);
    expect_rsp(8'hF0, 1'b0, 1'b0);
    req_write = 1'b0;
    req_addr  = 8'h12;
    req_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_strobes", 32'(bif.rb & bif.wb), 32'd1);
      cyc();
    end
    bif.ack = 1'b1;
    chk("hold_ready_last", 32'(req_ready), 32'd0);
    cyc();
    chk("queued_ready", 32'(req_ready), 32'd1);
    chk("queued_not_yet", 32'(bif.rb), 32'd1);
    cyc();
    req_valid = 1'b0;
    req_addr  = 8'hED;
    serve(1'b0, 8'h12, 8'h00, 1, 1'b0, 8'hF0, 1'b0);
    release_bus();

    // ACK stuck low after completion: RELEASE gives up after TO cycles.
    expect_rsp(8'hF0, 1'b0, 1'b0);
    issue(1'b1, 8'h25, 8'h10);
    serve(1'b1, 8'h25, 8'h10, 1, 1'b0, 8'h00, 1'b0);
    for (int j = 1; j <= TO; j++) begin
      chk("stuck_ack_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    chk("stuck_ack_exit", 32'(req_ready), 32'd1);
    bif.ack = 1'b1;
    cyc();

    // Read timeout leaves rsp_rdata unchanged.
    expect_rsp(8'hF0, 1'b0, 1'b1);
    issue(1'b0, 8'h26, 8'h00);
    serve(1'b0, 8'h26, 8'h00, TO, 1'b1, 8'h99, 1'b1);
    release_bus();

    // Reset mid-read: no response, bus released, then a normal write.
    issue(1'b0, 8'h44, 8'h00);
    bif.s_dout = 8'h55;
    bif.s_par  = 1'b0;
    bif.s_oe   = 1'b1;
    chk("midrd_rb", 32'(bif.rb), 32'd0);
    cyc();
    chk("midrd_rb2", 32'(bif.rb), 32'd0);
    chk("midrd_oe", 32'(bif.m_oe), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrd_rst_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("midrd_rst_rb", 32'(bif.rb), 32'd1);
    chk("midrd_rst_wb", 32'(bif.wb), 32'd1);
    chk("midrd_rst_oe", 32'(bif.m_oe), 32'd0);
    chk("midrd_no_rsp", 32'(rsp_valid), 32'd0);
    rst      = 1'b0;
    bif.s_oe = 1'b0;
    #1;
    chk("midrd_ready", 32'(req_ready), 32'd1);

    expect_rsp(8'h00, 1'b0, 1'b0);
    issue(1'b1, 8'h30, 8'h77);
    serve(1'b1, 8'h30, 8'h77, 2, 1'b0, 8'h00, 1'b0);
    release_bus();

    cyc();
    cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
